// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle ops plus iterative shift-add multiply.
// Define ALU_MC_DIV_EN to add iterative unsigned DIVU/REMU (restoring divider).
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       AluOp,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outBus,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOTA = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_DIVU = 4'b1000;
    localparam logic [3:0] OP_REMU = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1011;
    localparam logic [3:0] OP_SRA  = 4'b1100;
    localparam logic [3:0] OP_LUI  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aluStateT;

    aluStateT         state, stateNext;
    logic [3:0]       opReg, opNext;
    logic [WIDTH-1:0] acc, accNext;      // MUL partial product / DIV remainder
    logic [WIDTH-1:0] aReg, aNext;       // MUL multiplicand / DIV dividend-quotient
    logic [WIDTH-1:0] bReg, bNext;       // MUL multiplier / DIV divisor
    logic [SHW-1:0]   cnt, cntNext;
    logic [WIDTH-1:0] outBusNext;
    logic [WIDTH-1:0] quick;
    logic [WIDTH-1:0] mulAcc;
    logic [SHW-1:0]   shamt;
    logic             isIter;

    // Single-cycle result, computed straight from the operand buses at accept
    always_comb begin
        quick = '0;
        shamt = busB[SHW-1:0];
        case (AluOp)
            OP_AND:  quick = busA & busB;
            OP_OR:   quick = busA | busB;
            OP_XOR:  quick = busA ^ busB;
            OP_NOTA: quick = ~busA;
            OP_ADD:  quick = busA + busB;
            OP_SUB:  quick = busA - busB;
            OP_SLTU: quick = {{(WIDTH-1){1'b0}}, busA < busB};
            OP_SLT:  quick = {{(WIDTH-1){1'b0}}, $signed(busA) < $signed(busB)};
            OP_SLL:  quick = busA << shamt;
            OP_SRL:  quick = busA >> shamt;
            OP_SRA:  quick = $unsigned($signed(busA) >>> shamt);
            OP_LUI:  quick = busB << (WIDTH/2);
            default: quick = '0;
        endcase
    end

    always_comb begin
        isIter = (AluOp == OP_MUL);
`ifdef ALU_MC_DIV_EN
        if (AluOp == OP_DIVU || AluOp == OP_REMU) begin
            isIter = 1'b1;
        end
`endif
    end

    assign mulAcc = acc + (bReg[0] ? aReg : '0);

`ifdef ALU_MC_DIV_EN
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   remDiff;
    logic             remGeq;
    logic [WIDTH-1:0] remNew;
    logic [WIDTH-1:0] quoNew;

    // One restoring step; a zero divisor naturally yields all-ones quotient and remainder A
    always_comb begin
        remShift = {acc, aReg[WIDTH-1]};
        remDiff  = remShift - {1'b0, bReg};
        remGeq   = ~remDiff[WIDTH];
        remNew   = remGeq ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
        quoNew   = {aReg[WIDTH-2:0], remGeq};
    end
`endif

    // Next-state and datapath update
    always_comb begin
        stateNext  = state;
        opNext     = opReg;
        accNext    = acc;
        aNext      = aReg;
        bNext      = bReg;
        cntNext    = cnt;
        outBusNext = outBus;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    opNext = AluOp;
                    if (isIter) begin
                        stateNext = BUSY;
                        cntNext   = '0;
                        accNext   = '0;
                        aNext     = busA;
                        bNext     = busB;
                    end else begin
                        stateNext  = DONE;
                        outBusNext = quick;
                    end
                end
            end
            BUSY: begin
                if (opReg == OP_MUL) begin
                    accNext    = mulAcc;
                    aNext      = aReg << 1;
                    bNext      = bReg >> 1;
                    outBusNext = mulAcc;
                end
`ifdef ALU_MC_DIV_EN
                else begin
                    accNext    = remNew;
                    aNext      = quoNew;
                    outBusNext = (opReg == OP_DIVU) ? quoNew : remNew;
                end
`endif
                if (cnt == SHW'(WIDTH - 1)) begin
                    stateNext = DONE;
                end else begin
                    cntNext    = cnt + SHW'(1);
                    outBusNext = outBus;
                end
            end
            DONE: begin
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            opReg     <= '0;
            acc       <= '0;
            aReg      <= '0;
            bReg      <= '0;
            cnt       <= '0;
            outBus    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            opReg     <= opNext;
            acc       <= accNext;
            aReg      <= aNext;
            bReg      <= bNext;
            cnt       <= cntNext;
            outBus    <= outBusNext;
            in_ready  <= (stateNext == IDLE);
            out_valid <= (stateNext == DONE);
            busy      <= (stateNext == BUSY);
        end
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU with a valid/ready handshake, replacing the purely combinational datapath ALU in the execute stage. Single-cycle logic, arithmetic, shift and LUI operations produce a registered result. Iterative multiply and optional iterative unsigned divide/remainder take WIDTH cycles, and the block stalls the pipeline through the handshake while they run. One operation is in flight at a time.

## Interface
- WIDTH, 32: operand/result width; even, ≥ 8.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block accepts a request this cycle.
- AluOp  in  4  opcode, sampled on accept.
- busA  in  WIDTH  operand A, sampled on accept.
- busB  in  WIDTH  operand B, sampled on accept.
- out_valid  out  1  outBus holds a valid result.
- out_ready  in  1  consumer takes the result.
- outBus  out  WIDTH  registered result.
- busy  out  1  high while an iterative operation runs.

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 XOR, 0011 NOT A, 0100 ADD, 0101 SUB, 0110 SLTU (1 if A<B unsigned, else 0), 1110 SLT (signed), 1010 SLL A by B[SHW-1:0], 1011 SRL, 1100 SRA, 1101 LUI (B << WIDTH/2), 0111 MUL (low WIDTH bits of A*B), 1000 DIVU, 1001 REMU. Any other opcode returns 0 in one cycle.
- ADD/SUB/MUL wrap modulo 2^WIDTH. No flags are produced.
- FSM states:
  - IDLE: in_ready=1. An accept (in_valid & in_ready) latches the opcode and operands.
    - Single-cycle opcode: go to DONE, result computed into outBus.
    - MUL/DIVU/REMU: go to BUSY with an iteration counter = 0.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle.
    - After WIDTH steps, write the result to outBus and go to DONE.
    - in_ready=0, busy=1.
  - DONE: out_valid=1. outBus and out_valid are held stable until out_ready.
    - On out_valid & out_ready, go to IDLE.
    - in_ready=0 in DONE; there is no overlap of result and next accept.
- Divide by zero: DIVU returns all ones, REMU returns A. Both still take WIDTH cycles.
- Operands changing on the inputs after accept have no effect.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, outBus=0, state IDLE, counter 0.
- Reset asserted in any state aborts the operation. The cycle after reset deasserts shows the reset values; a pending result is discarded.
- Single-cycle op accepted at edge N: out_valid=1 from N+1.
- Iterative op accepted at edge N: busy=1 for edges N+1..N+WIDTH, out_valid=1 from N+WIDTH+1.
- Result taken at edge M (out_valid & out_ready): out_valid=0 and in_ready=1 from M+1. Earliest next accept is at M+1.
- out_ready high before out_valid has no effect.
- Throughput: at most one op per 2 cycles (single-cycle) or WIDTH+2 cycles (iterative).

## Configuration
- ALU_MC_DIV_EN defined: DIVU/REMU are implemented as above.
- ALU_MC_DIV_EN undefined: divider logic is removed. Opcodes 1000/1001 behave as unknown opcodes (result 0, one cycle, never busy).

## Test plan
- Reset, then ADD A=0xFFFFFFFF B=0x2, out_ready=1 -> outBus=0x00000001 with out_valid at accept+1; in_ready=1 the next cycle.
- SRA A=0x80000000 B=0x24 (amount 4) -> 0xF8000000. SLT A=0xFFFFFFFF B=1 -> 1. SLTU with the same operands -> 0. LUI B=0x1234 -> 0x12340000.
- MUL A=0x0001_0003 B=0x0001_0005 -> 0x0008_000F; busy high exactly 32 cycles; out_valid at accept+33.
- DIVU 100/7 -> 14, REMU 100/7 -> 2. DIVU x/0 -> 0xFFFFFFFF, REMU 100/0 -> 100. With ALU_MC_DIV_EN undefined, DIVU 100/7 -> 0 after 1 cycle.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> outBus and out_valid stable, in_ready=0, and in_valid with new operands is ignored. Release -> handshake, then a new accept.
- Reset asserted in BUSY mid-MUL (cycle 10) -> next cycle out_valid=0, busy=0, in_ready=1, outBus=0; a new SUB 5-7 returns 0xFFFFFFFE.
